// File: rtl/counter_pkg.sv
// Shared types and default constants for the counter stream and its receive-side checker.
package counter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEEK   = 2'd1,
    LOCKED = 2'd2
  } chk_state_t;

  localparam int COUNTER_W         = 8;
  localparam int COUNTER_RESET_VAL = 120;
  localparam int CHK_LOCK_COUNT    = 4;

  // Width of the correct-increment run counter; must be able to hold lock_count itself.
  function automatic int run_width(input int lock_count);
    return $clog2(lock_count + 1);
  endfunction

endpackage

// File: rtl/counter_checker_if.sv
// Sample/status bundle between a counter source (master) and counter_checker (slave).
interface counter_checker_if #(
  parameter int WIDTH     = counter_pkg::COUNTER_W,
  parameter int ERR_CNT_W = 16
);

  logic [WIDTH-1:0]     counter_input;
  logic                 in_valid;
  logic                 locked;
  logic                 error_pulse;
  logic [ERR_CNT_W-1:0] error_count;
  logic [ERR_CNT_W-1:0] wrap_count;
  logic [WIDTH-1:0]     expected;

  modport master (
    output counter_input, in_valid,
    input  locked, error_pulse, error_count, wrap_count, expected
  );

  modport slave (
    input  counter_input, in_valid,
    output locked, error_pulse, error_count, wrap_count, expected
  );

endinterface

// File: rtl/sat_counter.sv
// Registered up-counter that sticks at its all-ones value instead of rolling over.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX_VAL = {W{1'b1}};
  localparam logic [W-1:0] ONE_VAL = W'(1'b1);

  logic [W-1:0] count_r;

  // Count register: increments on inc unless already saturated.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {W{1'b0}};
    end else if (inc && (count_r != MAX_VAL)) begin
      count_r <= count_r + ONE_VAL;
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/counter_checker.sv
// Receive-side sequence checker for a +1 counter stream: seeks, locks, flags and counts breaks.
// Optional wrap counting is built when COUNTER_CHECKER_WRAP_EN is defined.
module counter_checker
  import counter_pkg::*;
#(
  parameter int WIDTH      = COUNTER_W,
  parameter int LOCK_COUNT = CHK_LOCK_COUNT,
  parameter int ERR_CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  counter_checker_if.slave bus
);

  localparam int               RUN_W    = run_width(LOCK_COUNT);
  localparam logic [RUN_W-1:0] LOCK_VAL = RUN_W'(LOCK_COUNT);
  localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1'b1);
  localparam logic [WIDTH-1:0] EXP_ONE  = WIDTH'(1'b1);

  chk_state_t           state_r;
  chk_state_t           state_nxt_s;
  logic [WIDTH-1:0]     expected_r;
  logic [WIDTH-1:0]     expected_nxt_s;
  logic [RUN_W-1:0]     run_r;
  logic [RUN_W-1:0]     run_nxt_s;
  logic [RUN_W-1:0]     run_inc_s;
  logic                 locked_r;
  logic                 error_pulse_r;
  logic                 err_s;
  logic                 match_s;
  logic [ERR_CNT_W-1:0] error_count_s;

  assign match_s   = (bus.counter_input == expected_r);
  assign run_inc_s = run_r + RUN_ONE;

  // State register together with the registered datapath and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      expected_r    <= {WIDTH{1'b0}};
      run_r         <= {RUN_W{1'b0}};
      locked_r      <= 1'b0;
      error_pulse_r <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      expected_r    <= expected_nxt_s;
      run_r         <= run_nxt_s;
      locked_r      <= (state_nxt_s == LOCKED);
      error_pulse_r <= err_s;
    end
  end

  // Next-state logic; nothing moves on cycles without a valid sample.
  always_comb begin
    state_nxt_s = state_r;
    if (bus.in_valid) begin
      case (state_r)
        IDLE: begin
          state_nxt_s = SEEK;
        end
        SEEK: begin
          if (match_s && (run_inc_s == LOCK_VAL)) begin
            state_nxt_s = LOCKED;
          end else begin
            state_nxt_s = SEEK;
          end
        end
        LOCKED: begin
          if (match_s) begin
            state_nxt_s = LOCKED;
          end else begin
            state_nxt_s = SEEK;
          end
        end
        default: begin
          state_nxt_s = IDLE;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Prediction, run length and break detection. A mismatch always re-seeds from the sample.
  always_comb begin
    expected_nxt_s = expected_r;
    run_nxt_s      = run_r;
    err_s          = 1'b0;
    if (bus.in_valid) begin
      case (state_r)
        SEEK: begin
          if (match_s) begin
            expected_nxt_s = expected_r + EXP_ONE;
            run_nxt_s      = run_inc_s;
          end else begin
            expected_nxt_s = bus.counter_input + EXP_ONE;
            run_nxt_s      = {RUN_W{1'b0}};
          end
        end
        LOCKED: begin
          if (match_s) begin
            expected_nxt_s = expected_r + EXP_ONE;
          end else begin
            err_s          = 1'b1;
            expected_nxt_s = bus.counter_input + EXP_ONE;
            run_nxt_s      = {RUN_W{1'b0}};
          end
        end
        default: begin
          expected_nxt_s = bus.counter_input + EXP_ONE;
          run_nxt_s      = {RUN_W{1'b0}};
        end
      endcase
    end else begin
      expected_nxt_s = expected_r;
      run_nxt_s      = run_r;
    end
  end

  sat_counter #(.W(ERR_CNT_W)) u_error_count (
    .clk   (clk),
    .rst   (rst),
    .inc   (err_s),
    .count (error_count_s)
  );

`ifdef COUNTER_CHECKER_WRAP_EN
  logic                 wrap_s;
  logic [ERR_CNT_W-1:0] wrap_count_s;

  // A wrap is a correct max-to-zero step observed while locked.
  assign wrap_s = bus.in_valid && (state_r == LOCKED) && match_s &&
                  (bus.counter_input == {WIDTH{1'b0}});

  sat_counter #(.W(ERR_CNT_W)) u_wrap_count (
    .clk   (clk),
    .rst   (rst),
    .inc   (wrap_s),
    .count (wrap_count_s)
  );

  assign bus.wrap_count = wrap_count_s;
`else
  assign bus.wrap_count = {ERR_CNT_W{1'b0}};
`endif

  assign bus.locked      = locked_r;
  assign bus.error_pulse = error_pulse_r;
  assign bus.error_count = error_count_s;
  assign bus.expected    = expected_r;

endmodule

// File: tb/tb_counter_checker.sv
// Scoreboard bench for counter_checker: two instances (wide and 2-bit event counters) share one stream.
module tb_counter_checker;
  import counter_pkg::*;

  localparam int LC   = CHK_LOCK_COUNT;
  localparam int EW_A = 16;
  localparam int EW_B = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] din;

  always #5 clk = ~clk;

  counter_checker_if #(.WIDTH(8), .ERR_CNT_W(EW_A)) bus_a ();
  counter_checker_if #(.WIDTH(8), .ERR_CNT_W(EW_B)) bus_b ();

  assign bus_a.counter_input = din;
  assign bus_a.in_valid      = in_valid;
  assign bus_b.counter_input = din;
  assign bus_b.in_valid      = in_valid;

  counter_checker #(.WIDTH(8), .LOCK_COUNT(LC), .ERR_CNT_W(EW_A)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  counter_checker #(.WIDTH(8), .LOCK_COUNT(LC), .ERR_CNT_W(EW_B)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  typedef struct {
    logic       lk;
    logic       ep;
    logic [7:0] ex;
    int         ec;
    int         wc;
  } resp_t;

  resp_t sb_q[$];
  int    checks = 0;
  int    errors = 0;

  // Reference model: last accepted sample and length of the current run of +1 steps.
  bit have_last = 1'b0;
  int last      = 0;
  int streak    = 0;
  int m_err     = 0;
  int m_wrap    = 0;
  bit m_pulse   = 1'b0;

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [7:0] d);
    resp_t e;
    @(negedge clk);
    rst      = r;
    in_valid = v;
    din      = d;
    @(posedge clk);
    #1;
    if (r) begin
      have_last = 1'b0;
      last      = 0;
      streak    = 0;
      m_err     = 0;
      m_wrap    = 0;
      m_pulse   = 1'b0;
    end else begin
      m_pulse = 1'b0;
      if (v) begin
        if (!have_last) begin
          have_last = 1'b1;
          streak    = 0;
        end else if (int'(d) == (last + 1) % 256) begin
          if (streak >= LC && d == 8'd0) m_wrap++;
          streak++;
        end else begin
          if (streak >= LC) begin
            m_pulse = 1'b1;
            m_err++;
          end
          streak = 0;
        end
        last = int'(d);
      end
    end
    e.lk = (streak >= LC);
    e.ep = m_pulse;
    e.ex = have_last ? 8'((last + 1) % 256) : 8'd0;
    e.ec = m_err;
    e.wc = m_wrap;
    sb_q.push_back(e);
  endtask

  // Monitor: compares the DUT outputs against the oldest queued expectation.
  always @(negedge clk) begin
    resp_t e;
    int    wa;
    int    wb;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
`ifdef COUNTER_CHECKER_WRAP_EN
      wa = sat(e.wc, EW_A);
      wb = sat(e.wc, EW_B);
`else
      wa = 0;
      wb = 0;
`endif
      chk("a_locked",      bus_a.locked,      e.lk);
      chk("a_error_pulse", bus_a.error_pulse, e.ep);
      chk("a_expected",    bus_a.expected,    e.ex);
      chk("a_error_count", bus_a.error_count, sat(e.ec, EW_A));
      chk("a_wrap_count",  bus_a.wrap_count,  wa);
      chk("b_locked",      bus_b.locked,      e.lk);
      chk("b_error_pulse", bus_b.error_pulse, e.ep);
      chk("b_error_count", bus_b.error_count, sat(e.ec, EW_B));
      chk("b_wrap_count",  bus_b.wrap_count,  wb);
    end
  end

  initial begin
    int  cur;
    int  base;
    int  r;
    logic [7:0] d;
    rst      = 1'b1;
    in_valid = 1'b0;
    din      = 8'd0;

    step(1'b1, 1'b0, 8'd0);
    step(1'b1, 1'b0, 8'd0);

    // Initial lock from the counter's reset value
    for (int v = 120; v <= 125; v++) step(1'b0, 1'b1, 8'(v));
    // Break while locked, then relock
    step(1'b0, 1'b1, 8'd130);
    for (int v = 131; v <= 134; v++) step(1'b0, 1'b1, 8'(v));
    // Relock near the top and cross the wrap
    for (int v = 249; v <= 255; v++) step(1'b0, 1'b1, 8'(v));
    step(1'b0, 1'b1, 8'd0);
    step(1'b0, 1'b1, 8'd1);
    // Stall keeps lock; stall with a skipped value breaks it
    repeat (5) step(1'b0, 1'b0, 8'd77);
    step(1'b0, 1'b1, 8'd2);
    repeat (3) step(1'b0, 1'b0, 8'd0);
    step(1'b0, 1'b1, 8'd4);
    for (int v = 5; v <= 8; v++) step(1'b0, 1'b1, 8'(v));
    // Five breaks, each followed by relock, to saturate the narrow counter
    for (int k = 0; k < 5; k++) begin
      base = 40 * k + 20;
      for (int j = 0; j <= LC; j++) step(1'b0, 1'b1, 8'(base + j));
    end
    // Reset together with a valid sample while locked, then re-seed
    step(1'b1, 1'b1, 8'd200);
    for (int v = 201; v <= 206; v++) step(1'b0, 1'b1, 8'(v));

    // Randomized stream: mostly in sequence with stalls, jumps and occasional resets
    cur = 207;
    for (int n = 0; n < 3000; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 2) begin
        step(1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
      end else if (r < 12) begin
        step(1'b0, 1'b0, 8'($urandom_range(0, 255)));
      end else if (r < 17) begin
        d = 8'($urandom_range(0, 255));
        step(1'b0, 1'b1, d);
        cur = (int'(d) + 1) % 256;
      end else begin
        step(1'b0, 1'b1, 8'(cur));
        cur = (cur + 1) % 256;
      end
    end

    step(1'b0, 1'b0, 8'd0);
    @(negedge clk);
    @(negedge clk);
    chk("queue_drain", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/counter_checker.md
# counter_checker

Receive-side monitor for the free-running 8-bit counter stream produced by `counter`. It samples the counter value each valid cycle and predicts the next value (+1, modulo 2^WIDTH). It locks after a run of correct increments and flags and counts every break in sequence once locked. It sits downstream of `counter` (or any link carrying its output) as a continuous integrity checker for bring-up and regression.

## Interface
- `WIDTH`, default 8: width of the sampled counter value.
- `LOCK_COUNT`, default 4: number of consecutive correct increments required to lock; legal range 1..255.
- `ERR_CNT_W`, default 16: width of the saturating event counters.

- `clk`  in  1  rising-edge clock for all state.
- `rst`  in  1  synchronous, active-high reset.
- `counter_input`  in  WIDTH  sampled counter value.
- `in_valid`  in  1  `counter_input` is meaningful this cycle. Tie high for a free-running source.
- `locked`  out  1  sequence is being tracked correctly.
- `error_pulse`  out  1  single-cycle flag for a sequence break while locked.
- `error_count`  out  ERR_CNT_W  saturating count of `error_pulse` events.
- `wrap_count`  out  ERR_CNT_W  saturating count of locked wraps from max to 0.
- `expected`  out  WIDTH  value predicted for the next valid sample.

## Operation
- FSM states: IDLE, SEEK, LOCKED. All state updates only on cycles with `in_valid`=1. With `in_valid`=0, all state holds and `error_pulse`=0.
- IDLE:
  - On the first valid sample, set `expected` = sample+1 and `run` = 0, then go to SEEK.
- SEEK, sample == `expected`:
  - `run` increments and `expected` increments.
  - If `run`+1 == LOCK_COUNT, go to LOCKED.
- SEEK, sample != `expected`:
  - Set `expected` = sample+1 and `run` = 0.
  - No error is raised; the block keeps seeking.
- LOCKED, sample == `expected`:
  - `expected` increments.
  - If the sample is 0 (a wrap), `wrap_count` increments.
- LOCKED, sample != `expected`:
  - `error_pulse` = 1 for one cycle and `error_count` increments.
  - Set `expected` = sample+1 and `run` = 0, then go to SEEK.
- Arithmetic:
  - All `expected` arithmetic is modulo 2^WIDTH; 2^WIDTH−1 followed by 0 is a correct increment.
  - `run` has width clog2(LOCK_COUNT+1).
- Counters saturate at 2^ERR_CNT_W−1 and never roll over.

## Timing
- All outputs are registered. The effect of a sample accepted at edge N is visible after edge N.
- Lock latency: the first sample enters SEEK. `locked` rises after the edge that accepts the LOCK_COUNT-th correct successor.
- `error_pulse` is high for exactly the cycle following the edge that accepted the bad sample.
- Reset values: state IDLE, `locked` 0, `error_pulse` 0, `error_count` 0, `wrap_count` 0, `expected` 0, `run` 0.
- If `rst` and `in_valid` are high in the same cycle, `rst` wins and the sample is discarded.
- Reset mid-run clears the counters and lock. The next valid sample re-seeds from IDLE.
- A stall (`in_valid`=0) in LOCKED does not break lock. A gap in the source value on resume is treated as an error.

## Configuration
- `COUNTER_CHECKER_WRAP_EN` defined: wrap detection logic and the `wrap_count` register are built.
- Not defined: `wrap_count` is a constant 0 and no wrap logic is synthesized. The port stays present so instantiations are unchanged.

## Structure
- Package `counter_pkg`:
  - `typedef enum logic [1:0] {IDLE, SEEK, LOCKED} chk_state_t`.
  - Default constants `COUNTER_W`=8, `COUNTER_RESET_VAL`=120, `CHK_LOCK_COUNT`=4.
- Sub-module `sat_counter` (parameter W; ports `clk`, `rst`, `inc`, `count`): saturating up-counter, instantiated for `error_count` and `wrap_count`.

## Test plan
- Reset, then valid samples 120,121,122,123,124 → `locked`=0 through the sample 123 edge, then 1 after 124; `expected`=125; no `error_pulse`.
- Locked, then feed 130 when 126 is expected → one-cycle `error_pulse`, `error_count`=1, `locked`=0, `expected`=131. Then 131..134 → relocked.
- Locked, then feed 254,255,0,1 → no error, `locked` held. `wrap_count`=1 with `COUNTER_CHECKER_WRAP_EN`, 0 without.
- Locked, then `in_valid` low for 5 cycles, then the next value in sequence → `locked` stays 1 and there is no error. `in_valid` low with a skipped value → `error_pulse`.
- `ERR_CNT_W`=2, then 5 forced breaks each followed by relock → `error_count` stays at 3.
- `rst` asserted together with `in_valid` mid-lock → next cycle all outputs at reset values; the next sample re-seeds from IDLE.
